// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

   localparam int REG_W_DEF = 5;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } state_e;

   // bit positions in the stage enable/clear vectors
   localparam int STG_IFID  = 0;
   localparam int STG_IDEX  = 1;
   localparam int STG_EXMEM = 2;
   localparam int STG_MEMWB = 3;
   localparam int N_STG     = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard/sequencing bundle between the datapath and the pipeline controller.
interface pipe_hazard_ctrl_if
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_W = REG_W_DEF
);
   logic [REG_W-1:0] id_r1;
   logic [REG_W-1:0] id_r2;
   logic             id_r1_used;
   logic             id_r2_used;
   logic             ex_memtoreg;
   logic             ex_regwrite;
   logic [REG_W-1:0] ex_write_reg;
   logic             ex_redirect;
   logic             mem_busy;
   logic             wb_syscall;
   logic             resume;

   logic             pc_en;
   logic             ifid_en;
   logic             idex_en;
   logic             exmem_en;
   logic             memwb_en;
   logic             ifid_clr;
   logic             idex_clr;
   logic             exmem_clr;
   logic             memwb_clr;
   logic             halted;
   logic             mem_err;
   logic [1:0]       state;

   modport master (
      output id_r1, id_r2, id_r1_used, id_r2_used, ex_memtoreg, ex_regwrite,
             ex_write_reg, ex_redirect, mem_busy, wb_syscall, resume,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_clr, idex_clr, exmem_clr, memwb_clr, halted, mem_err, state
   );

   modport slave (
      input  id_r1, id_r2, id_r1_used, id_r2_used, ex_memtoreg, ex_regwrite,
             ex_write_reg, ex_redirect, mem_busy, wb_syscall, resume,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_clr, idex_clr, exmem_clr, memwb_clr, halted, mem_err, state
   );

endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator: a load in EX feeding a source read in ID.
module load_use_detect
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_W = REG_W_DEF
) (
   input  logic [REG_W-1:0] id_r1,
   input  logic [REG_W-1:0] id_r2,
   input  logic             id_r1_used,
   input  logic             id_r2_used,
   input  logic             ex_memtoreg,
   input  logic             ex_regwrite,
   input  logic [REG_W-1:0] ex_write_reg,
   output logic             load_use
);

   logic r1_hit;
   logic r2_hit;

   assign r1_hit   = id_r1_used & (id_r1 == ex_write_reg);
   assign r2_hit   = id_r2_used & (id_r2 == ex_write_reg);
   // $0 is hardwired, so a load targeting it never creates a dependency
   assign load_use = ex_memtoreg & ex_regwrite & (ex_write_reg != '0) & (r1_hit | r2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stalls, flushes, memory waits, syscall halt.
// Optional perf counters (cyc/stall/flush) are built when PIPE_PERF_CNT_EN is defined.
//
// state    | meaning
// RUN      | normal issue; load-use bubble and redirect flush handled here
// MEM_WAIT | data memory busy, whole pipe frozen, timeout down-counter running
// HALT     | syscall or memory timeout; resume rising edge exits unless mem_err
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_W       = REG_W_DEF,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   pipe_hazard_ctrl_if.slave  hz
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]   cyc_cnt,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   flush_cnt
`endif
);

   // wait timer counts down from MEM_TIMEOUT-1 (loaded on entry) to zero
   localparam logic [7:0] WCNT_LOAD = 8'(MEM_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [7:0]       wcnt_q, wcnt_d;
   logic             resume_q;
   logic             mem_err_q, mem_err_d;
   logic             load_use;
   logic             resume_rise;
   logic             pc_en_c;
   logic             halted_c;
   logic [N_STG-1:0] stg_en;
   logic [N_STG-1:0] stg_clr;

   load_use_detect #(.REG_W(REG_W)) u_lud (
      .id_r1        (hz.id_r1),
      .id_r2        (hz.id_r2),
      .id_r1_used   (hz.id_r1_used),
      .id_r2_used   (hz.id_r2_used),
      .ex_memtoreg  (hz.ex_memtoreg),
      .ex_regwrite  (hz.ex_regwrite),
      .ex_write_reg (hz.ex_write_reg),
      .load_use     (load_use)
   );

   assign resume_rise = hz.resume & ~resume_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RUN;
         wcnt_q    <= '0;
         resume_q  <= 1'b0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         resume_q  <= hz.resume;
         mem_err_q <= mem_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      mem_err_d = mem_err_q;
      pc_en_c   = 1'b0;
      stg_en    = '0;
      stg_clr   = '0;
      halted_c  = 1'b0;
      case (state_q)
         RUN: begin
            if (hz.mem_busy) begin
               state_d = MEM_WAIT;
               wcnt_d  = WCNT_LOAD;
            end else if (hz.wb_syscall) begin
               state_d = HALT;
            end else if (hz.ex_redirect) begin
               pc_en_c            = 1'b1;
               stg_en             = '1;
               stg_clr[STG_IFID]  = 1'b1;
               stg_clr[STG_IDEX]  = 1'b1;
            end else if (load_use) begin
               stg_en[STG_EXMEM]  = 1'b1;
               stg_en[STG_MEMWB]  = 1'b1;
               stg_clr[STG_IDEX]  = 1'b1;
            end else begin
               pc_en_c = 1'b1;
               stg_en  = '1;
            end
         end
         MEM_WAIT: begin
            if (!hz.mem_busy) begin
               state_d = RUN;
            end else if (wcnt_q == '0) begin
               mem_err_d = 1'b1;
               state_d   = HALT;
            end else begin
               wcnt_d = wcnt_q - 8'd1;
            end
         end
         HALT: begin
            halted_c = 1'b1;
            // one full-advance cycle lets the syscall retire out of WB
            if (resume_rise && !mem_err_q) begin
               state_d = RUN;
               pc_en_c = 1'b1;
               stg_en  = '1;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // reset forces every stage register to clear regardless of state
   assign hz.pc_en     = rst_n & pc_en_c;
   assign hz.ifid_en   = rst_n & stg_en[STG_IFID];
   assign hz.idex_en   = rst_n & stg_en[STG_IDEX];
   assign hz.exmem_en  = rst_n & stg_en[STG_EXMEM];
   assign hz.memwb_en  = rst_n & stg_en[STG_MEMWB];
   assign hz.ifid_clr  = ~rst_n | stg_clr[STG_IFID];
   assign hz.idex_clr  = ~rst_n | stg_clr[STG_IDEX];
   assign hz.exmem_clr = ~rst_n | stg_clr[STG_EXMEM];
   assign hz.memwb_clr = ~rst_n | stg_clr[STG_MEMWB];
   assign hz.halted    = rst_n & halted_c;
   assign hz.mem_err   = mem_err_q;
   assign hz.state     = state_q;

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             run_free;

   assign run_free = (state_q == RUN) & ~hz.mem_busy & ~hz.wb_syscall;

   always_comb begin
      cyc_cnt_d   = cyc_cnt_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (state_q != HALT)
         cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
      if (((state_q == RUN) & hz.mem_busy) | (state_q == MEM_WAIT) |
          (run_free & ~hz.ex_redirect & load_use))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (run_free & hz.ex_redirect)
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_cnt_q   <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         cyc_cnt_q   <= cyc_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign cyc_cnt   = cyc_cnt_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed, table-driven bench for pipe_hazard_ctrl (default build, MEM_TIMEOUT=15).
module tb_pipe_hazard_ctrl;
   import pipe_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   pipe_hazard_ctrl_if #(.REG_W(5)) hz ();

   pipe_hazard_ctrl #(.REG_W(5), .MEM_TIMEOUT(15), .CNT_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz)
   );

   always #5 clk = ~clk;

   // expected word: {pc,ifid,idex,exmem,memwb en} {ifid,idex,exmem,memwb clr} halted mem_err state[1:0]
   localparam logic [4:0] EN_ALL   = 5'b11111;
   localparam logic [4:0] EN_NONE  = 5'b00000;
   localparam logic [4:0] EN_STALL = 5'b00011;
   localparam logic [3:0] CL_NONE  = 4'b0000;
   localparam logic [3:0] CL_ALL   = 4'b1111;
   localparam logic [3:0] CL_BUB   = 4'b0100;
   localparam logic [3:0] CL_FLUSH = 4'b1100;

   typedef struct {
      string      name;
      logic [4:0] r1, r2;
      logic       u1, u2, m2r, rw;
      logic [4:0] wr;
      logic       redir;
      logic [12:0] exp;
   } vec_t;

   int n_pass = 0;
   int n_tot  = 0;
   vec_t vecs[9];

   function automatic vec_t mk(input string nm, input logic [4:0] r1, input logic [4:0] r2,
                               input logic u1, input logic u2, input logic m2r, input logic rw,
                               input logic [4:0] wr, input logic redir, input logic [12:0] exp);
      vec_t v;
      v.name = nm; v.r1 = r1; v.r2 = r2; v.u1 = u1; v.u2 = u2;
      v.m2r = m2r; v.rw = rw; v.wr = wr; v.redir = redir; v.exp = exp;
      return v;
   endfunction

   task automatic check(input string name, input logic [12:0] exp);
      logic [12:0] act;
      act = {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en,
             hz.ifid_clr, hz.idex_clr, hz.exmem_clr, hz.memwb_clr,
             hz.halted, hz.mem_err, hz.state};
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", name, act, exp);
   endtask

   task automatic idle_inputs();
      hz.id_r1 = '0; hz.id_r2 = '0; hz.id_r1_used = 1'b0; hz.id_r2_used = 1'b0;
      hz.ex_memtoreg = 1'b0; hz.ex_regwrite = 1'b0; hz.ex_write_reg = '0;
      hz.ex_redirect = 1'b0; hz.mem_busy = 1'b0; hz.wb_syscall = 1'b0; hz.resume = 1'b0;
   endtask

   // advance one clock; inputs change 1ns after the edge, checks run mid-cycle
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      #3;
      check("reset_outputs", {EN_NONE, CL_ALL, 1'b0, 1'b0, 2'd0});
      tick();
      rst_n = 1'b1;
      #3;
   endtask

   initial begin
      vecs[0] = mk("idle",          5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, {EN_ALL,   CL_NONE,  2'b00, 2'd0});
      vecs[1] = mk("lu_rs",         5'd8, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, {EN_STALL, CL_BUB,   2'b00, 2'd0});
      vecs[2] = mk("after_bubble",  5'd8, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, {EN_ALL,   CL_NONE,  2'b00, 2'd0});
      vecs[3] = mk("lu_rt",         5'd4, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, {EN_STALL, CL_BUB,   2'b00, 2'd0});
      vecs[4] = mk("rt_unused",     5'd4, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, {EN_ALL,   CL_NONE,  2'b00, 2'd0});
      vecs[5] = mk("lu_reg0",       5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, {EN_ALL,   CL_NONE,  2'b00, 2'd0});
      vecs[6] = mk("load_no_wr",    5'd8, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0, {EN_ALL,   CL_NONE,  2'b00, 2'd0});
      vecs[7] = mk("redir_over_lu", 5'd8, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, {EN_ALL,   CL_FLUSH, 2'b00, 2'd0});
      vecs[8] = mk("redir",         5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, {EN_ALL,   CL_FLUSH, 2'b00, 2'd0});

      do_reset();

      foreach (vecs[i]) begin
         hz.id_r1 = vecs[i].r1; hz.id_r2 = vecs[i].r2;
         hz.id_r1_used = vecs[i].u1; hz.id_r2_used = vecs[i].u2;
         hz.ex_memtoreg = vecs[i].m2r; hz.ex_regwrite = vecs[i].rw;
         hz.ex_write_reg = vecs[i].wr; hz.ex_redirect = vecs[i].redir;
         #3;
         check(vecs[i].name, vecs[i].exp);
         tick();
      end
      idle_inputs();

      // three-cycle memory wait
      hz.mem_busy = 1'b1; #3; check("mw_entry", {EN_NONE, CL_NONE, 2'b00, 2'd0}); tick();
      #3; check("mw_1", {EN_NONE, CL_NONE, 2'b00, 2'd1}); tick();
      #3; check("mw_2", {EN_NONE, CL_NONE, 2'b00, 2'd1}); tick();
      hz.mem_busy = 1'b0; #3; check("mw_exit", {EN_NONE, CL_NONE, 2'b00, 2'd1}); tick();
      #3; check("mw_back_run", {EN_ALL, CL_NONE, 2'b00, 2'd0}); tick();

      // syscall halt and resume edge detection
      hz.wb_syscall = 1'b1; #3; check("sys_entry", {EN_NONE, CL_NONE, 2'b00, 2'd0}); tick();
      #3; check("sys_halt", {EN_NONE, CL_NONE, 2'b10, 2'd2}); tick();
      hz.resume = 1'b1; #3; check("resume_rise", {EN_ALL, CL_NONE, 2'b10, 2'd2}); tick();
      hz.wb_syscall = 1'b0; #3; check("resumed_run", {EN_ALL, CL_NONE, 2'b00, 2'd0}); tick();
      hz.wb_syscall = 1'b1; #3; check("sys2_entry", {EN_NONE, CL_NONE, 2'b00, 2'd0}); tick();
      #3; check("resume_held_1", {EN_NONE, CL_NONE, 2'b10, 2'd2}); tick();
      #3; check("resume_held_2", {EN_NONE, CL_NONE, 2'b10, 2'd2}); tick();
      hz.resume = 1'b0; #3; check("resume_low", {EN_NONE, CL_NONE, 2'b10, 2'd2}); tick();
      hz.resume = 1'b1; #3; check("resume_rise2", {EN_ALL, CL_NONE, 2'b10, 2'd2}); tick();
      hz.wb_syscall = 1'b0; hz.resume = 1'b0; #3; check("run_again", {EN_ALL, CL_NONE, 2'b00, 2'd0});

      // asynchronous reset mid-RUN clears immediately
      rst_n = 1'b0; #1; check("async_reset", {EN_NONE, CL_ALL, 2'b00, 2'd0});
      tick(); rst_n = 1'b1; #3;

      // memory timeout: entry cycle + 15 wait cycles, then HALT with mem_err
      hz.mem_busy = 1'b1; #3; check("to_entry", {EN_NONE, CL_NONE, 2'b00, 2'd0}); tick();
      for (int c = 1; c < 15; c++) tick();
      #3; check("to_last_wait", {EN_NONE, CL_NONE, 2'b00, 2'd1}); tick();
      #3; check("to_halt", {EN_NONE, CL_NONE, 2'b11, 2'd2}); tick();
      hz.mem_busy = 1'b0; hz.resume = 1'b1; #3; check("to_resume_ignored", {EN_NONE, CL_NONE, 2'b11, 2'd2}); tick();
      hz.resume = 1'b0; #3; check("to_still_halt", {EN_NONE, CL_NONE, 2'b11, 2'd2}); tick();

      rst_n = 1'b0; #1; check("to_reset_clears_err", {EN_NONE, CL_ALL, 2'b00, 2'd0});
      tick(); rst_n = 1'b1; #3;
      check("post_reset_run", {EN_ALL, CL_NONE, 2'b00, 2'd0});

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage MIPS pipeline.
- Drives the enable/clear pair of every stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable.
- Handles load-use stalls, taken-branch/jump flushes, multi-cycle data-memory waits with timeout, and syscall halt/resume.
- Sits beside the datapath; all stage registers take their Enable/clr from this block.

Parameters:
REG_W, 5, register-number width
MEM_TIMEOUT, 15, max consecutive mem_busy cycles before error halt (1..255)
CNT_W, 32, width of the performance counters (PERF_CNT_EN only)

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
id_r1  in  REG_W  ID-stage rs number
id_r2  in  REG_W  ID-stage rt number
id_r1_used  in  1  ID instruction reads rs
id_r2_used  in  1  ID instruction reads rt
ex_memtoreg  in  1  EX instruction is a load
ex_regwrite  in  1  EX instruction writes the register file
ex_write_reg  in  REG_W  EX destination register
ex_redirect  in  1  EX resolved a taken branch, jr, j or jal
mem_busy  in  1  data memory has not completed the MEM-stage access
wb_syscall  in  1  halting syscall is in WB
resume  in  1  level "go" input, edge-detected internally
pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage load enables
ifid_clr, idex_clr, exmem_clr, memwb_clr  out  1 each  stage synchronous clears
halted  out  1  controller is in HALT
mem_err  out  1  sticky, set when a memory-wait timeout occurs
state  out  2  current state: RUN=0, MEM_WAIT=1, HALT=2

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=RUN, wait counter=0, resume_q=0, mem_err=0.
  - While rst_n is low, all *_en=0, all *_clr=1, halted=0.
- Outputs are combinational from state and inputs; state, counter, resume_q and mem_err are registered.
- load_use = ex_memtoreg & ex_regwrite & ex_write_reg!=0 & ((id_r1_used & id_r1==ex_write_reg) | (id_r2_used & id_r2==ex_write_reg)).
- resume_rise = resume & ~resume_q; resume_q <= resume every cycle.
- RUN priority, highest first:
  - mem_busy: all en=0, clr=0. Next state MEM_WAIT, counter=1.
  - wb_syscall: all en=0, clr=0. Next state HALT.
  - ex_redirect: all en=1, ifid_clr=1, idex_clr=1. Branch wins over a simultaneous load_use.
  - load_use: pc_en=0, ifid_en=0, idex_clr=1, exmem_en=1, memwb_en=1. One bubble per hazard detection.
  - Otherwise: all en=1, all clr=0.
- MEM_WAIT:
  - All en=0, clr=0.
  - mem_busy=0: next state RUN. The normal RUN rules apply from the following cycle.
  - mem_busy=1 and counter==MEM_TIMEOUT: mem_err<=1, next state HALT.
  - Otherwise counter increments; it never wraps past MEM_TIMEOUT.
- HALT:
  - halted=1, all en=0, clr=0.
  - resume_rise with mem_err=0: next state RUN. In that cycle all en=1 so the syscall leaves WB, and wb_syscall is ignored.
  - mem_err=1: resume is ignored; only reset exits.
- Clears are ORed with nothing else; a register with clr=1 and en=0 still clears (clear dominates in the stage registers).
- Reset asserted mid-stall or mid-wait aborts immediately to the reset values above.

Optional Feature:
PIPE_PERF_CNT_EN:
- Defined: adds outputs cyc_cnt, stall_cnt, flush_cnt, each CNT_W bits.
  - cyc_cnt counts every cycle outside HALT.
  - stall_cnt counts load_use bubbles plus MEM_WAIT-entry and MEM_WAIT cycles.
  - flush_cnt counts ex_redirect cycles.
  - All reset to 0 and wrap modulo 2^CNT_W.
- Undefined: these ports and registers do not exist.

Decomposition:
- Package pipe_ctrl_pkg holds the state enum (RUN, MEM_WAIT, HALT), the REG_W default, and the stage-index constants.
- One sub-module, load_use_detect: purely combinational load_use comparator, instantiated once.
- The FSM, counters and edge detector stay in pipe_hazard_ctrl.

Test Plan:
- lw $8 in EX (ex_memtoreg=1, ex_regwrite=1, ex_write_reg=8), ID add reads id_r1=8 used -> one cycle pc_en=0, ifid_en=0, idex_clr=1; next cycle all en=1.
- Same hazard with ex_write_reg=0 -> no stall, all en=1.
- ex_redirect=1 together with load_use=1 -> ifid_clr=1, idex_clr=1, pc_en=1, no stall.
- mem_busy high for 3 cycles -> state=1 for 3 cycles, all en=0; returns to RUN; mem_err=0.
- mem_busy held 16+ cycles with MEM_TIMEOUT=15 -> mem_err=1, halted=1; a resume pulse does not leave HALT.
- wb_syscall=1 -> HALT, resume held high leaves HALT only once on its rising edge (all en=1 for that cycle); then rst_n pulse low mid-RUN -> all clr=1 immediately.
